// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit (MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them).
// Latency 3 cycles minimum, +1 per DMEM_BUSYWAIT cycle; BUSYWAIT stalls the pipeline until the DONE cycle.
module mem_access_unit #(
  parameter int MAX_WAIT = 0,
  parameter int CNT_W    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED,
  output logic        TIMEOUT,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [29:0] DMEM_ADDRESS,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  input  logic [31:0] DMEM_READDATA,
  input  logic        DMEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;

  logic             request, is_byte, is_half, is_word, misaligned_req, start, timeout_hit;
  logic [31:0]      acc_addr, st_data, ld_data;
  logic [3:0]       st_be;
  logic [31:0]      addr_q, wdata_q, read_data_q;
  logic [2:0]       func3_q;
  logic [3:0]       be_q;
  logic             rd_q, timeout_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign request = MEM_READ | MEM_WRITE;
  assign is_byte = (FUNC3[1:0] == 2'b00);
  assign is_half = (FUNC3[1:0] == 2'b01);
  assign is_word = FUNC3[1];

`ifdef MISALIGN_TRAP_EN
  assign misaligned_req = request & ((is_half & ADDRESS[0]) | (is_word & (|ADDRESS[1:0])));
  assign acc_addr       = ADDRESS;
`else
  // Without the trap, misaligned halves/words are silently aligned down.
  assign misaligned_req = 1'b0;
  assign acc_addr       = {ADDRESS[31:2], ADDRESS[1] & ~is_word, ADDRESS[0] & ~is_word & ~is_half};
`endif

  assign start       = (state == IDLE) & request & ~misaligned_req;
  assign timeout_hit = (MAX_WAIT != 0) && DMEM_BUSYWAIT && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    st_data = WRITE_DATA;
    st_be   = 4'b1111;
    if (!MEM_READ) begin
      if (is_byte) begin
        st_data = {4{WRITE_DATA[7:0]}};
        st_be   = 4'b0001 << acc_addr[1:0];
      end else if (is_half) begin
        st_data = {2{WRITE_DATA[15:0]}};
        st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCESS;
      ACCESS:  if (!DMEM_BUSYWAIT || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset gates the combinational outputs so the stall releases without a clock edge.
  always_comb begin
    BUSYWAIT   = ~RESET & (((state == IDLE) & request & ~misaligned_req) | (state == ACCESS));
    MISALIGNED = ~RESET & (state == IDLE) & misaligned_req;
    DMEM_READ  = (state == ACCESS) & rd_q;
    DMEM_WRITE = (state == ACCESS) & ~rd_q;
    READ_DATA  = MISALIGNED ? 32'h0 : read_data_q;
  end

  assign DMEM_ADDRESS   = addr_q[31:2];
  assign DMEM_WRITEDATA = wdata_q;
  assign DMEM_BYTE_EN   = be_q;
  assign TIMEOUT        = timeout_q;

  always_comb begin
    byte_sel = DMEM_READDATA[8*addr_q[1:0] +: 8];
    half_sel = addr_q[1] ? DMEM_READDATA[31:16] : DMEM_READDATA[15:0];
    case (func3_q)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = DMEM_READDATA;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      func3_q     <= '0;
      rd_q        <= 1'b0;
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
      read_data_q <= '0;
    end else begin
      if (start) begin
        addr_q   <= acc_addr;
        wdata_q  <= st_data;
        be_q     <= st_be;
        func3_q  <= FUNC3;
        rd_q     <= MEM_READ;
        wait_cnt <= '0;
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      timeout_q <= (state == ACCESS) & timeout_hit;
      if (state == ACCESS && timeout_hit)
        read_data_q <= '0;
      else if (state == ACCESS && !DMEM_BUSYWAIT && rd_q)
        read_data_q <= ld_data;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit; sits directly upstream of the MEM/WB pipeline register.
- Takes ALU address, store data, FUNC3 and read/write controls from EX/MEM, drives the word-wide data memory handshake, and stalls the pipeline via BUSYWAIT.
- Formats load data (byte/half extraction, sign/zero extension), which feeds IN_DMEM_OUT of MEM/WB.

Parameters:
- MAX_WAIT, 0: max ACCESS cycles before abort; 0 = no timeout.
- CNT_W, 8: width of wait counter; MAX_WAIT must be < 2^CNT_W.

Ports:
- CLK  in  1  clock, posedge.
- RESET  in  1  asynchronous, active-high reset.
- MEM_READ  in  1  load request from EX/MEM.
- MEM_WRITE  in  1  store request from EX/MEM.
- FUNC3  in  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ADDRESS  in  32  byte address (ALU result).
- WRITE_DATA  in  32  rs2 store data.
- READ_DATA  out  32  formatted load result to MEM/WB.
- BUSYWAIT  out  1  pipeline stall.
- MISALIGNED  out  1  misaligned-access flag.
- TIMEOUT  out  1  one-cycle pulse, access aborted.
- DMEM_READ  out  1  memory read strobe.
- DMEM_WRITE  out  1  memory write strobe.
- DMEM_ADDRESS  out  30  word address, ADDRESS[31:2].
- DMEM_WRITEDATA  out  32  lane-replicated store data.
- DMEM_BYTE_EN  out  4  byte lane enables.
- DMEM_READDATA  in  32  memory read word.
- DMEM_BUSYWAIT  in  1  memory not ready.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All DMEM_* outputs, READ_DATA, MISALIGNED and TIMEOUT go to 0; BUSYWAIT goes to 0.
  - In-flight access is dropped; no write completes after reset asserts.
- States:
  - IDLE -> ACCESS: a valid request is seen at posedge.
  - ACCESS -> DONE: DMEM_BUSYWAIT sampled 0 at posedge, or timeout.
  - DONE -> IDLE: unconditional at the next posedge.
- Request and stall:
  - Request = MEM_READ | MEM_WRITE. If both are high, the read is performed and the write is ignored.
  - BUSYWAIT = (IDLE & request & !MISALIGNED) | ACCESS. It is combinational, so the stall begins in the same cycle the request appears.
  - DONE: BUSYWAIT=0 so MEM/WB latches READ_DATA; the next instruction enters at that edge.
- IDLE -> ACCESS capture: ADDRESS, FUNC3, read/write select and formatted store data/byte enables are registered. DMEM_* is driven only from these registered values.
- ACCESS:
  - DMEM_READ or DMEM_WRITE is held at 1.
  - On exit, DMEM_READ/WRITE drop to 0.
  - For loads, DMEM_READDATA is formatted into the READ_DATA register.
- Minimum latency: 3 cycles (request, ACCESS, DONE), i.e. 2 stall cycles. Each extra DMEM_BUSYWAIT cycle adds one.
- Store formatting:
  - SB: byte replicated to all 4 lanes; BYTE_EN = 1 << addr[1:0].
  - SH: half replicated; BYTE_EN = 0011 if addr[1]=0, else 1100.
  - SW: BYTE_EN = 1111.
  - Loads: BYTE_EN = 1111.
- Load formatting:
  - Byte lane is selected by addr[1:0]; half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - FUNC3 011/110/111 are treated as word access.
- READ_DATA: holds its value until the next completed load. Stores leave it unchanged.
- Timeout (MAX_WAIT>0):
  - Counter clears on entering ACCESS and increments each ACCESS cycle.
  - If the count reaches MAX_WAIT while DMEM_BUSYWAIT=1: go to DONE, pulse TIMEOUT for 1 cycle, set READ_DATA=0.
  - With MAX_WAIT=0, TIMEOUT is tied to 0.
- Request dropped while in ACCESS: ignored. The registered access completes.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - MISALIGNED = request & ((half & addr[0]) | (word & addr[1:0]!=0)), combinational, in IDLE only.
  - A misaligned request never leaves IDLE, asserts no DMEM strobe and no BUSYWAIT, and READ_DATA is forced to 0 in that cycle.
- Undefined:
  - MISALIGNED is tied to 0.
  - Offending low address bits are cleared: half -> addr[0]=0; word -> addr[1:0]=0.
  - The access then proceeds normally.

Test Plan:
- SW 0xDEADBEEF @0x100, memory zero-wait -> BUSYWAIT high 2 cycles; DMEM_WRITE 1 cycle; DMEM_ADDRESS=0x40, BYTE_EN=1111.
- LB @0x103, memory word 0x80FF7F01, 3 wait cycles -> READ_DATA=0xFFFFFF80 in DONE; BUSYWAIT high 5 cycles. Same access with LBU -> READ_DATA=0x00000080.
- SH 0x1234ABCD @0x0A -> DMEM_WRITEDATA=0xABCDABCD, BYTE_EN=1100. Then LHU @0x0A with memory word 0xABCD0000 -> READ_DATA=0x0000ABCD.
- MISALIGN_TRAP_EN defined, LW @0x102 -> MISALIGNED=1, BUSYWAIT=0, no DMEM strobe. Undefined -> access to word 0x40 with MISALIGNED=0.
- MAX_WAIT=4, DMEM_BUSYWAIT stuck at 1 -> TIMEOUT pulses after 4 ACCESS cycles; READ_DATA=0; FSM returns to IDLE.
- RESET asserted mid-ACCESS of SW -> DMEM_WRITE and BUSYWAIT drop to 0 without waiting for a clock edge; state IDLE; next LW completes normally.
